// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the 4x4 LED group controller.
package led_ctrl_pkg;

  localparam int N_GROUPS = 4;
  localparam int GROUP_W  = 4;
  localparam int LED_W    = N_GROUPS * GROUP_W;

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_t;

  typedef logic [N_GROUPS-1:0] grp_mask_t;

  // Isolates the lowest set bit, so simultaneous presses resolve to the lowest group.
  function automatic grp_mask_t lowest_onehot(input grp_mask_t m);
    return m & grp_mask_t'(~m + grp_mask_t'(1));
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Synchronizes one raw asynchronous input and debounces it; emits registered edge pulses.
module pb_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic        sync0;
  logic        sync1;
  logic [15:0] cnt;
  logic        flip;

  // The level flips on the cycle the disagreement has lasted DEBOUNCE_CYCLES cycles.
  assign flip = (sync1 != level) && (cnt == DEBOUNCE_CYCLES - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 == level || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (flip) begin
        level <= ~level;
      end
      rise <= flip & ~level;
      fall <= flip & level;
    end
  end

endmodule

// File: rtl/led_group_ctrl.sv
// Board LED controller: debounced buttons drive a per-group enable mask in MANUAL
// mode, or pick/rotate a single lit group in AUTO mode.
module led_group_ctrl
  import led_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] STEP_CYCLES     = 32'd50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LED_W-1:0]    sw,
  input  logic [N_GROUPS-1:0] pb,
  input  logic                auto_en,
  output logic [LED_W-1:0]    led,
  output logic [N_GROUPS-1:0] grp_en,
  output logic                mode
);

  grp_mask_t   press;
  grp_mask_t   pb_level;
  grp_mask_t   pb_fall;
  logic        auto_level;
  logic        auto_rise;
  logic        auto_fall;

  mode_t       state;
  mode_t       state_next;
  grp_mask_t   grp_en_next;
  grp_mask_t   saved_mask;
  grp_mask_t   saved_mask_next;
  logic [31:0] step_cnt;
  logic [31:0] step_cnt_next;
  logic [LED_W-1:0] led_next;

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_pb
    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb (
      .clk   (clk),
      .rst   (rst),
      .raw   (pb[g]),
      .level (pb_level[g]),
      .rise  (press[g]),
      .fall  (pb_fall[g])
    );
  end

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
    .clk   (clk),
    .rst   (rst),
    .raw   (auto_en),
    .level (auto_level),
    .rise  (auto_rise),
    .fall  (auto_fall)
  );

  // Button levels and release edges carry no action here.
  logic unused_levels;
  assign unused_levels = ^{pb_level, pb_fall, auto_level};

  assign mode = (state == AUTO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MANUAL;
      grp_en     <= 4'hF;
      saved_mask <= 4'hF;
      step_cnt   <= '0;
      led        <= '0;
    end else begin
      state      <= state_next;
      grp_en     <= grp_en_next;
      saved_mask <= saved_mask_next;
      step_cnt   <= step_cnt_next;
      led        <= led_next;
    end
  end

  // Mode transitions take precedence over presses, which take precedence over rotation.
  always_comb begin
    state_next      = state;
    grp_en_next     = grp_en;
    saved_mask_next = saved_mask;
    step_cnt_next   = step_cnt;
    unique case (state)
      MANUAL: begin
        if (auto_rise) begin
          state_next      = AUTO;
          saved_mask_next = grp_en;
          grp_en_next     = 4'b0001;
          step_cnt_next   = '0;
        end else begin
          grp_en_next = grp_en ^ press;
        end
      end
      AUTO: begin
        if (auto_fall) begin
          state_next    = MANUAL;
          grp_en_next   = saved_mask;
          step_cnt_next = '0;
        end else if (|press) begin
          grp_en_next   = lowest_onehot(press);
          step_cnt_next = '0;
        end else if (step_cnt == STEP_CYCLES - 32'd1) begin
          grp_en_next   = {grp_en[N_GROUPS-2:0], grp_en[N_GROUPS-1]};
          step_cnt_next = '0;
        end else begin
          step_cnt_next = step_cnt + 32'd1;
        end
      end
      default: state_next = MANUAL;
    endcase
  end

  always_comb begin
    led_next = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      led_next[g*GROUP_W +: GROUP_W] = sw[g*GROUP_W +: GROUP_W] & {GROUP_W{grp_en[g]}};
    end
  end

endmodule

// File: tb/tb_led_group_ctrl.sv
// Directed self-checking bench for led_group_ctrl with short debounce and step periods.
module tb_led_group_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [3:0]  pb;
  logic        auto_en;
  logic [15:0] led;
  logic [3:0]  grp_en;
  logic        mode;

  int passed;
  int total;

  led_group_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .STEP_CYCLES    (32'd8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .pb      (pb),
    .auto_en (auto_en),
    .led     (led),
    .grp_en  (grp_en),
    .mode    (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("[TB] %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b0;
    sw      = 16'hFFFF;
    pb      = 4'h0;
    auto_en = 1'b0;

    // Reset and release
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_led",    led,           16'h0000);
    checkOutput("rst_grp",    {12'h0, grp_en}, 16'h000F);
    checkOutput("rst_mode",   {15'h0, mode}, 16'h0000);
    tick(2);
    checkOutput("rst_hold_led", led, 16'h0000);
    rst = 1'b0;
    tick(2);
    checkOutput("rel_led", led, 16'hFFFF);

    // Glitch shorter than the debounce window
    pb = 4'b0010;
    tick(3);
    pb = 4'b0000;
    tick(10);
    checkOutput("glitch_grp", {12'h0, grp_en}, 16'h000F);

    // Held press on group 1
    pb = 4'b0010;
    tick(6);
    checkOutput("press1_early", {12'h0, grp_en}, 16'h000F);
    tick(1);
    checkOutput("press1_grp", {12'h0, grp_en}, 16'h000D);
    tick(1);
    checkOutput("press1_led", led, 16'hFF0F);
    pb = 4'b0000;
    tick(10);
    checkOutput("release1_grp", {12'h0, grp_en}, 16'h000D);
    pb = 4'b0010;
    tick(7);
    checkOutput("press1b_grp", {12'h0, grp_en}, 16'h000F);
    pb = 4'b0000;
    tick(10);

    // Simultaneous presses, then a bouncy release
    pb = 4'b1001;
    tick(7);
    checkOutput("simul_grp", {12'h0, grp_en}, 16'h0006);
    pb = 4'b0000;
    tick(2);
    pb = 4'b1001;
    tick(2);
    pb = 4'b0000;
    tick(1);
    pb = 4'b1001;
    tick(1);
    pb = 4'b0000;
    tick(12);
    checkOutput("bounce_grp",  {12'h0, grp_en}, 16'h0006);
    checkOutput("manual_mode", {15'h0, mode},   16'h0000);

    // Enter AUTO and rotate
    auto_en = 1'b1;
    tick(7);
    checkOutput("auto_grp",  {12'h0, grp_en}, 16'h0001);
    checkOutput("auto_mode", {15'h0, mode},   16'h0001);
    tick(1);
    checkOutput("auto_led0", led, 16'h000F);
    tick(6);
    checkOutput("rot_hold", {12'h0, grp_en}, 16'h0001);
    tick(1);
    checkOutput("rot_2", {12'h0, grp_en}, 16'h0002);
    tick(1);
    checkOutput("rot_led1", led, 16'h00F0);
    tick(7);
    checkOutput("rot_4", {12'h0, grp_en}, 16'h0004);
    tick(8);
    checkOutput("rot_8", {12'h0, grp_en}, 16'h0008);
    tick(8);
    checkOutput("rot_wrap", {12'h0, grp_en}, 16'h0001);

    // Jump by press in AUTO; step counter restarts
    pb = 4'b1100;
    tick(7);
    checkOutput("jump_grp", {12'h0, grp_en}, 16'h0004);
    tick(7);
    checkOutput("jump_hold", {12'h0, grp_en}, 16'h0004);
    tick(1);
    checkOutput("jump_rot", {12'h0, grp_en}, 16'h0008);

    // Exit AUTO with a coinciding press that must be dropped
    pb      = 4'b0001;
    auto_en = 1'b0;
    tick(7);
    checkOutput("exit_grp",  {12'h0, grp_en}, 16'h0006);
    checkOutput("exit_mode", {15'h0, mode},   16'h0000);
    tick(10);
    checkOutput("exit_hold", {12'h0, grp_en}, 16'h0006);
    checkOutput("exit_led",  led, 16'h0FF0);
    sw = 16'h1234;
    tick(1);
    checkOutput("sw_follow", led, 16'h0230);
    pb = 4'b0000;
    tick(10);

    // Reset mid-debounce drops the pending press
    sw = 16'hFFFF;
    pb = 4'b0100;
    tick(5);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst2_led",  led,             16'h0000);
    checkOutput("rst2_grp",  {12'h0, grp_en}, 16'h000F);
    pb = 4'b0000;
    tick(1);
    rst = 1'b0;
    tick(12);
    checkOutput("rst2_nopress", {12'h0, grp_en}, 16'h000F);
    checkOutput("rst2_led_on",  led,             16'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
